uart_tx_scheduler: RTL and testbench

//  Round-robin scheduler that shares one UART_TX_TOP between NUM_REQ requesters (e.g. ALU result, RegFile read).

---
 rtl/uart_tx_scheduler.sv | 132 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding 1/2-byte messages from NUM_REQ requesters into one UART TX, one frame at a time.
// Request-to-Data_Valid latency 2 cycles; requests wait (never dropped) while TX_BUSY is high or a message is in flight.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int BUSY_TO = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [16*NUM_REQ-1:0]  i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_two_byte,
    input  logic                   i_cfg_par_en,
    input  logic                   i_cfg_par_typ,
    input  logic                   i_tx_busy,
    output logic [7:0]             o_tx_p_data,
    output logic                   o_tx_data_valid,
    output logic                   o_tx_par_en,
    output logic                   o_tx_par_typ,
    output logic [NUM_REQ-1:0]     o_req_ack,
    output logic                   o_tx_err,
    output logic                   o_sched_busy
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(BUSY_TO);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_HI, S_WAIT_LO, S_DONE} state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [15:0]         r_data;
    logic                r_two;
    logic                r_idx;
    logic                r_par_en;
    logic                r_par_typ;
    logic [TW-1:0]       r_timer;
    logic [NUM_REQ-1:0]  w_req;
    logic                w_found;
    logic [PW-1:0]       w_grant;

    // A requester being acked this cycle still shows its stale valid; keep it out of arbitration.
    assign w_req = i_req_valid & ~o_req_ack;

    always_comb begin
        w_found = 1'b0;
        w_grant = r_ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_found && w_req[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_grant = PW'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_ptr           <= PW'(NUM_REQ - 1);
            r_data          <= '0;
            r_two           <= 1'b0;
            r_idx           <= 1'b0;
            r_par_en        <= 1'b0;
            r_par_typ       <= 1'b0;
            r_timer         <= '0;
            o_tx_p_data     <= '0;
            o_tx_data_valid <= 1'b0;
            o_tx_par_en     <= 1'b0;
            o_tx_par_typ    <= 1'b0;
            o_req_ack       <= '0;
            o_tx_err        <= 1'b0;
            o_sched_busy    <= 1'b0;
        end else begin
            o_tx_data_valid <= 1'b0;
            o_req_ack       <= '0;
            o_tx_err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found && !i_tx_busy) begin
                        r_ptr        <= w_grant;
                        r_data       <= i_req_data[int'(w_grant)*16 +: 16];
                        r_two        <= i_req_two_byte[w_grant];
                        r_par_en     <= i_cfg_par_en;
                        r_par_typ    <= i_cfg_par_typ;
                        r_state      <= S_LOAD;
                        o_sched_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    o_tx_p_data     <= r_idx ? r_data[15:8] : r_data[7:0];
                    o_tx_par_en     <= r_par_en;
                    o_tx_par_typ    <= r_par_typ;
                    o_tx_data_valid <= 1'b1;
                    r_timer         <= '0;
                    r_state         <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (i_tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end else if (r_timer == TW'(BUSY_TO - 1)) begin
                        o_tx_err     <= 1'b1;
                        o_req_ack    <= NUM_REQ'(1) << r_ptr;
                        r_idx        <= 1'b0;
                        r_state      <= S_IDLE;
                        o_sched_busy <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!i_tx_busy) begin
                        if (!r_idx && r_two) begin
                            r_idx   <= 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            // Ack is raised on entry so it is visible for the whole DONE cycle.
                            o_req_ack <= NUM_REQ'(1) << r_ptr;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_idx        <= 1'b0;
                    r_state      <= S_IDLE;
                    o_sched_busy <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    o_sched_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: behavioural TX model, requester drivers, round-robin reference model.
module tb_uart_tx_scheduler;
    localparam int NR = 3;
    localparam int TO = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [16*NR-1:0]   req_data;
    logic [NR-1:0]      req_two;
    logic               cfg_en, cfg_typ, tx_busy;
    logic [7:0]         p_data;
    logic               dv, par_en, par_typ, err, sbusy;
    logic [NR-1:0]      ack;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit tx_dead;
    int tx_delay, tx_len;

    logic [16:0] msgs[NR][4];
    int nmsg[NR];
    int mptr[NR];
    int nm[NR];
    int raise_cyc[NR];
    int m_ptr;

    logic [9:0] got_f[$];
    int         got_fc[$];
    int         got_a[$];
    logic [9:0] exp_f[$];
    int         exp_a[$];
    int err_cnt = 0;
    int err_cyc = 0;
    int err_base;

    uart_tx_scheduler #(.NUM_REQ(NR), .BUSY_TO(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
        .i_req_two_byte(req_two), .i_cfg_par_en(cfg_en), .i_cfg_par_typ(cfg_typ),
        .i_tx_busy(tx_busy), .o_tx_p_data(p_data), .o_tx_data_valid(dv),
        .o_tx_par_en(par_en), .o_tx_par_typ(par_typ), .o_req_ack(ack),
        .o_tx_err(err), .o_sched_busy(sbusy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART TX model: busy rises tx_delay cycles after Data_Valid and stays up tx_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (dv && !tx_dead) begin
                repeat (tx_delay - 1) @(negedge clk);
                tx_busy = 1'b1;
                repeat (tx_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        int a_idx;
        forever begin
            @(negedge clk);
            if (dv) begin
                got_f.push_back({par_en, par_typ, p_data});
                got_fc.push_back(cyc);
            end
            if (ack != '0) begin
                a_idx = -1;
                if ($countones(ack) == 1)
                    for (int r = 0; r < NR; r++) if (ack[r]) a_idx = r;
                got_a.push_back(a_idx);
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    // Requesters: hold valid until ack, then present their next queued message.
    initial forever begin
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            if (ack[r]) begin
                req_valid[r] = 1'b0;
                mptr[r]++;
            end
            if (!req_valid[r] && mptr[r] < nmsg[r]) begin
                req_valid[r]        = 1'b1;
                req_data[16*r +: 16] = msgs[r][mptr[r]][15:0];
                req_two[r]          = msgs[r][mptr[r]][16];
                raise_cyc[r]        = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: every requester with messages left is pending at each arbitration point,
    // so the winner is simply the next one after the last winner that still has work.
    task automatic model_round(input bit pe, input bit pt);
        int left[NR];
        int pos[NR];
        int total;
        int c;
        logic [16:0] m;
        total = 0;
        for (int r = 0; r < NR; r++) begin
            left[r] = nm[r];
            pos[r]  = 0;
            total  += nm[r];
        end
        while (total > 0) begin
            c = -1;
            for (int k = 1; k <= NR; k++)
                if (c < 0 && left[(m_ptr + k) % NR] > 0) c = (m_ptr + k) % NR;
            m_ptr = c;
            m = msgs[c][pos[c]];
            exp_f.push_back({pe, pt, m[7:0]});
            if (m[16]) exp_f.push_back({pe, pt, m[15:8]});
            exp_a.push_back(c);
            pos[c]++;
            left[c]--;
            total--;
        end
    endtask

    task automatic commit(input bit pe, input bit pt);
        cfg_en  = pe;
        cfg_typ = pt;
        got_f.delete(); got_fc.delete(); got_a.delete();
        exp_f.delete(); exp_a.delete();
        err_base = err_cnt;
        model_round(pe, pt);
        for (int r = 0; r < NR; r++) mptr[r] = 0;
        for (int r = 0; r < NR; r++) nmsg[r] = nm[r];
    endtask

    task automatic wait_acks(input string tag, input int n);
        int left;
        left = 3000;
        while (got_a.size() < n && left > 0) begin
            @(posedge clk);
            left--;
        end
        chk({tag, "_done_in_time"}, 64'(got_a.size() >= n), 64'd1);
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n);
        int left;
        left = 500;
        while (got_f.size() < n && left > 0) begin
            @(posedge clk);
            left--;
        end
        chk("frame_seen_in_time", 64'(got_f.size() >= n), 64'd1);
    endtask

    task automatic compare_round(input string tag);
        chk($sformatf("%s_nframes", tag), 64'(got_f.size()), 64'(exp_f.size()));
        for (int i = 0; i < exp_f.size() && i < got_f.size(); i++)
            chk($sformatf("%s_frame%0d", tag, i), 64'(got_f[i]), 64'(exp_f[i]));
        chk($sformatf("%s_nacks", tag), 64'(got_a.size()), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
            chk($sformatf("%s_ack%0d", tag, i), 64'(got_a[i]), 64'(exp_a[i]));
        chk($sformatf("%s_no_err", tag), 64'(err_cnt), 64'(err_base));
        chk($sformatf("%s_idle", tag), 64'(sbusy), 64'd0);
    endtask

    task automatic clear_nm();
        for (int r = 0; r < NR; r++) nm[r] = 0;
    endtask

    initial begin
        int a0;
        rst = 1'b1; req_valid = '0; req_data = '0; req_two = '0;
        cfg_en = 1'b0; cfg_typ = 1'b0; tx_dead = 1'b0; tx_delay = 2; tx_len = 10;
        for (int r = 0; r < NR; r++) begin nmsg[r] = 0; mptr[r] = 0; raise_cyc[r] = 0; end
        m_ptr = NR - 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 64'({p_data, dv, par_en, par_typ, ack, err, sbusy}), 64'd0);

        // Single byte, latency
        @(posedge clk); #1;
        clear_nm(); nm[0] = 1; msgs[0][0] = {1'b0, 16'h00A5};
        commit(1'b0, 1'b0);
        wait_acks("t1", exp_a.size());
        compare_round("t1");
        if (got_fc.size() > 0)
            chk("t1_latency", 64'(got_fc[0] - raise_cyc[0]), 64'd2);

        // Two-byte message, LSB first
        clear_nm(); nm[1] = 1; msgs[1][0] = {1'b1, 16'hBEEF};
        commit(1'b0, 1'b0);
        wait_acks("t2", exp_a.size());
        compare_round("t2");

        // Contention: req0 two messages, req1 one
        clear_nm(); nm[0] = 2; nm[1] = 1;
        for (int k = 0; k < 2; k++) msgs[0][k] = {1'($urandom_range(0, 1)), 16'($urandom)};
        msgs[1][0] = {1'($urandom_range(0, 1)), 16'($urandom)};
        commit(1'b1, 1'b1);
        wait_acks("t3", exp_a.size());
        compare_round("t3");

        // Timeout: TX never goes busy
        tx_dead = 1'b1;
        clear_nm(); nm[1] = 1; msgs[1][0] = {1'b1, 16'h5A3C};
        cfg_en = 1'b0; cfg_typ = 1'b0;
        got_f.delete(); got_fc.delete(); got_a.delete();
        err_base = err_cnt;
        for (int r = 0; r < NR; r++) mptr[r] = 0;
        for (int r = 0; r < NR; r++) nmsg[r] = nm[r];
        wait_acks("t4", 1);
        chk("t4_err_count", 64'(err_cnt - err_base), 64'd1);
        chk("t4_nframes", 64'(got_f.size()), 64'd1);
        chk("t4_nacks", 64'(got_a.size()), 64'd1);
        if (got_a.size() > 0) chk("t4_ack_req", 64'(got_a[0]), 64'd1);
        if (got_fc.size() > 0) chk("t4_err_delay", 64'(err_cyc - got_fc[0]), 64'(TO));
        chk("t4_idle", 64'(sbusy), 64'd0);
        m_ptr = 1;
        tx_dead = 1'b0;

        // Parity config changed mid-message
        tx_delay = 1; tx_len = 8;
        clear_nm(); nm[0] = 1; msgs[0][0] = {1'b1, 16'h1234};
        commit(1'b1, 1'b0);
        wait_frames(1);
        repeat (3) @(posedge clk);
        #1 cfg_en = 1'b0;
        wait_acks("t5a", exp_a.size());
        compare_round("t5a");
        clear_nm(); nm[1] = 1; msgs[1][0] = {1'b0, 16'h0077};
        commit(1'b0, 1'b0);
        wait_acks("t5b", exp_a.size());
        compare_round("t5b");

        // Reset mid-frame
        tx_delay = 1; tx_len = 10;
        clear_nm(); nm[0] = 1; msgs[0][0] = {1'b1, 16'hC3D2};
        commit(1'b0, 1'b0);
        wait_frames(1);
        repeat (3) @(posedge clk);
        #1;
        a0 = got_a.size();
        rst = 1'b1;
        req_valid[0] = 1'b0;
        nmsg[0] = mptr[0];
        @(negedge clk);
        chk("t6_reset_outputs", 64'({p_data, dv, par_en, par_typ, ack, err, sbusy}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_ptr = NR - 1;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_no_ack", 64'(got_a.size()), 64'(a0));
        clear_nm(); nm[2] = 1; msgs[2][0] = {1'b1, 16'h9ABC};
        commit(1'b1, 1'b1);
        wait_acks("t6b", exp_a.size());
        compare_round("t6b");

        // Randomized rounds
        for (int rd = 0; rd < 6; rd++) begin
            tx_delay = $urandom_range(1, 3);
            tx_len   = $urandom_range(2, 12);
            for (int r = 0; r < NR; r++) begin
                nm[r] = $urandom_range(0, 3);
                for (int k = 0; k < 4; k++) msgs[r][k] = {1'($urandom_range(0, 1)), 16'($urandom)};
            end
            if (nm[0] + nm[1] + nm[2] == 0) nm[rd % NR] = 1;
            commit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_acks($sformatf("rnd%0d", rd), exp_a.size());
            compare_round($sformatf("rnd%0d", rd));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
